// File: rtl/icache_refill_ctrl_if.sv
// Bundle of the cache-side miss/fill signals and the main-memory read
// handshake used by the I-cache refill controller.
// The master modport is the refill controller. The slave modport is the
// cache and memory side that drives misses and memory responses.
interface icache_refill_ctrl_if;
  // cache side
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        flush;
  logic        access_mm;
  logic [31:0] data_mm;
  // memory side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  miss_req, miss_addr, flush, mem_ack, mem_rdata,
    output mem_req, mem_addr, access_mm, data_mm
  );

  modport slave (
    output miss_req, miss_addr, flush, mem_ack, mem_rdata,
    input  mem_req, mem_addr, access_mm, data_mm
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Miss/refill controller behind the direct-mapped I-cache.
// A miss is accepted only in IDLE. The word is fetched over a req/ack
// handshake, and a minimum miss penalty is enforced before the single-cycle
// fill strobe is returned to the cache. A flush abandons a refill before
// FILL. Saturating counters record completed refills and busy cycles.
module icache_refill_ctrl #(
  parameter int MIN_LAT = 4,
  parameter int CNT_W   = 20,
  parameter int LAT_W   = 8
) (
  input  logic                 clk,
  input  logic                 RESET,
  icache_refill_ctrl_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     cnt_refill,
  output logic [CNT_W-1:0]     cnt_stall
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [LAT_W-1:0] MIN_LAT_L  = LAT_W'(MIN_LAT);
  localparam logic [LAT_W:0]   MIN_LAT_X  = (LAT_W+1)'(MIN_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [31:0]      ALIGN_MASK = 32'hFFFF_FFFC;

  // Saturating increment: the counters stick at all-ones and never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  state_t           state_r;
  logic [LAT_W-1:0] lat_cnt_r;
  logic [31:0]      addr_r;
  logic [31:0]      buf_r;
  logic             mem_req_r;
  logic             access_mm_r;
  logic [31:0]      data_mm_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_refill_r;
  logic [CNT_W-1:0] cnt_stall_r;

  logic [LAT_W:0]   lat_inc_s;
  logic             lat_reached_s;
  logic [LAT_W-1:0] lat_next_s;

  // One extra bit keeps lat_cnt+1 from overflowing when it is compared
  // with MIN_LAT. The counter itself stops at MIN_LAT.
  assign lat_inc_s     = {1'b0, lat_cnt_r} + {{LAT_W{1'b0}}, 1'b1};
  assign lat_reached_s = (lat_inc_s >= MIN_LAT_X);
  assign lat_next_s    = (lat_cnt_r >= MIN_LAT_L) ? MIN_LAT_L : lat_inc_s[LAT_W-1:0];

  // Refill sequencer with all handshake outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_r     <= S_IDLE;
      lat_cnt_r   <= {LAT_W{1'b0}};
      addr_r      <= 32'h0000_0000;
      buf_r       <= 32'h0000_0000;
      mem_req_r   <= 1'b0;
      access_mm_r <= 1'b0;
      data_mm_r   <= 32'h0000_0000;
      busy_r      <= 1'b0;
    end else begin
      access_mm_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.miss_req && !bus.flush) begin
            addr_r    <= bus.miss_addr & ALIGN_MASK;
            lat_cnt_r <= {LAT_W{1'b0}};
            mem_req_r <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= S_REQ;
          end else begin
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        S_REQ: begin
          lat_cnt_r <= lat_next_s;
          if (bus.mem_ack) begin
            // The beat is consumed even when a flush discards it.
            buf_r     <= bus.mem_rdata;
            mem_req_r <= 1'b0;
            if (bus.flush) begin
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end else if (lat_reached_s) begin
              access_mm_r <= 1'b1;
              data_mm_r   <= bus.mem_rdata;
              state_r     <= S_FILL;
            end else begin
              state_r <= S_WAIT;
            end
          end else if (bus.flush) begin
            // Withdraw the request. Memory tolerates a dropped req.
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= S_IDLE;
          end else begin
            state_r <= S_REQ;
          end
        end
        S_WAIT: begin
          lat_cnt_r <= lat_next_s;
          if (bus.flush) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if (lat_reached_s) begin
            access_mm_r <= 1'b1;
            data_mm_r   <= buf_r;
            state_r     <= S_FILL;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_FILL: begin
          // The fill is already committed. A flush here is ignored.
          state_r <= S_DONE;
        end
        S_DONE: begin
          // A stale miss_req from the cache is ignored for this one cycle.
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          mem_req_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  // Statistics: completed fills and busy cycles, both saturating.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      cnt_refill_r <= {CNT_W{1'b0}};
      cnt_stall_r  <= {CNT_W{1'b0}};
    end else begin
      if (access_mm_r) begin
        cnt_refill_r <= sat_inc(cnt_refill_r);
      end else begin
        cnt_refill_r <= cnt_refill_r;
      end
      if (busy_r) begin
        cnt_stall_r <= sat_inc(cnt_stall_r);
      end else begin
        cnt_stall_r <= cnt_stall_r;
      end
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_addr  = addr_r;
  assign bus.access_mm = access_mm_r;
  assign bus.data_mm   = data_mm_r;
  assign busy          = busy_r;
  assign cnt_refill    = cnt_refill_r;
  assign cnt_stall     = cnt_stall_r;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a fill scoreboard.
// The stimulus pushes the expected fill word, address and latency for each
// miss. A monitor pops and compares one entry on every access_mm pulse.
module tb_icache_refill_ctrl;

  logic        clk;
  logic        RESET;
  logic        busy;
  logic [19:0] cnt_refill;
  logic [19:0] cnt_stall;
  logic        busy4;
  logic [3:0]  cnt_refill4;
  logic [3:0]  cnt_stall4;

  icache_refill_ctrl_if bus();
  icache_refill_ctrl_if bus4();

  icache_refill_ctrl #(.MIN_LAT(4), .CNT_W(20), .LAT_W(8)) dut (
    .clk(clk), .RESET(RESET), .bus(bus),
    .busy(busy), .cnt_refill(cnt_refill), .cnt_stall(cnt_stall)
  );

  icache_refill_ctrl #(.MIN_LAT(4), .CNT_W(4), .LAT_W(8)) dut4 (
    .clk(clk), .RESET(RESET), .bus(bus4),
    .busy(busy4), .cnt_refill(cnt_refill4), .cnt_stall(cnt_stall4)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    int          lat;
  } fill_t;

  fill_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    req_start = 0;
  logic  prev_req = 1'b0;
  int    exp_refill = 0;
  int    exp_stall = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: timestamp each new request and score every fill pulse.
  always @(negedge clk) begin
    fill_t e;
    if (bus.mem_req && !prev_req) req_start = cyc;
    prev_req = bus.mem_req;
    if (bus.access_mm === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fill_unexpected: data %h addr %h at cycle %0d", bus.data_mm, bus.mem_addr, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_mm !== e.data || bus.mem_addr !== e.addr || (cyc - req_start) != e.lat) begin
          errors++;
          $display("FAIL fill: got data %h addr %h lat %0d expected data %h addr %h lat %0d",
                   bus.data_mm, bus.mem_addr, cyc - req_start, e.data, e.addr, e.lat);
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_access_mm"}, {31'd0, bus.access_mm}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0000_0000);
    chk({tag, "_data_mm"}, bus.data_mm, 32'h0000_0000);
    chk({tag, "_cnt_refill"}, {12'd0, cnt_refill}, 32'd0);
    chk({tag, "_cnt_stall"}, {12'd0, cnt_stall}, 32'd0);
  endtask

  // One miss. ack_at/flush_at are REQ-relative cycle indices (-1 = never).
  // hold keeps miss_req high afterwards; already means the miss is already
  // being driven and will be accepted on the next edge.
  task automatic miss_txn(input string name, input logic [31:0] addr, input logic [31:0] rdata,
                          input int ack_at, input int flush_at, input bit exp_fill,
                          input int exp_lat, input int exp_busy, input bit hold, input bit already);
    logic [31:0] exp_addr;
    int          k;
    bit          exp_req;
    fill_t       f;
    exp_addr = {addr[31:2], 2'b00};
    if (!already) @(negedge clk);
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    @(negedge clk);
    if (!hold) bus.miss_req = 1'b0;
    chk({name, "_mem_addr"}, bus.mem_addr, exp_addr);
    if (exp_fill) begin
      f.data = rdata;
      f.addr = exp_addr;
      f.lat  = exp_lat;
      exp_q.push_back(f);
      exp_refill++;
    end
    k = 0;
    while (k < 40 && (k == 0 || busy)) begin
      exp_req = (k <= ack_at) && (flush_at < 0 || k <= flush_at);
      chk({name, "_mem_req"}, {31'd0, bus.mem_req}, {31'd0, exp_req});
      if (exp_req) chk({name, "_addr_stable"}, bus.mem_addr, exp_addr);
      bus.mem_ack   = ((k == ack_at) && bus.mem_req) ? 1'b1 : 1'b0;
      bus.mem_rdata = (k == ack_at) ? rdata : 32'h0000_0000;
      bus.flush     = (k == flush_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.flush   = 1'b0;
      k++;
    end
    exp_stall += exp_busy;
    chk({name, "_busy_cycles"}, k, exp_busy);
    chk({name, "_idle_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({name, "_cnt_refill"}, {12'd0, cnt_refill}, exp_refill);
    chk({name, "_cnt_stall"}, {12'd0, cnt_stall}, exp_stall);
  endtask

  initial begin
    RESET          = 1'b0;
    bus.miss_req   = 1'b0;
    bus.miss_addr  = 32'h0000_0000;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0000_0000;
    bus4.miss_req  = 1'b0;
    bus4.miss_addr = 32'h0000_0000;
    bus4.flush     = 1'b0;
    bus4.mem_ack   = 1'b0;
    bus4.mem_rdata = 32'h0000_0000;
    repeat (3) @(negedge clk);
    reset_checks("por");
    RESET = 1'b1;

    // basic miss: ack on first REQ cycle, fill 4 cycles after req, 6 busy cycles
    miss_txn("basic", 32'h0000_0047, 32'hDEAD_BEEF, 0, -1, 1'b1, 4, 6, 1'b0, 1'b0);

    // reset held for 2 clocks in the middle of WAIT
    @(negedge clk);
    bus.miss_req  = 1'b1;
    bus.miss_addr = 32'h0000_0100;
    @(negedge clk);
    bus.miss_req  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    RESET = 1'b0;
    @(negedge clk);
    chk("rst_first_edge_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_checks("rst_wait");
    RESET = 1'b1;
    exp_refill = 0;
    exp_stall  = 0;
    repeat (2) @(negedge clk);
    chk("rst_after_access", {31'd0, bus.access_mm}, 32'd0);

    // slow memory: ack on the 10th REQ cycle, fill on the next cycle
    miss_txn("slow", 32'h1000_0003, 32'hA5A5_5A5A, 9, -1, 1'b1, 10, 12, 1'b0, 1'b0);
    // flush in REQ before ack, the late ack is never driven
    miss_txn("flush_req", 32'h0000_0200, 32'h5555_AAAA, 3, 1, 1'b0, 0, 2, 1'b0, 1'b0);
    // flush in WAIT discards the buffered word
    miss_txn("flush_wait", 32'h0000_0204, 32'h6666_BBBB, 0, 2, 1'b0, 0, 3, 1'b0, 1'b0);
    // next miss is normal; ack on cycle 3 is exactly at the minimum latency
    miss_txn("top_addr", 32'hFFFF_FFFF, 32'h0BAD_F00D, 3, -1, 1'b1, 4, 6, 1'b0, 1'b0);
    // flush together with ack in REQ: data consumed, no fill
    miss_txn("flush_ack", 32'h0000_0300, 32'h7777_CCCC, 2, 2, 1'b0, 0, 3, 1'b0, 1'b0);
    // flush during FILL does not cancel the pulse
    miss_txn("flush_fill", 32'h0000_0400, 32'h1357_9BDF, 0, 4, 1'b1, 4, 6, 1'b0, 1'b0);
    // miss_req held through DONE: one refill, next one starts from IDLE
    miss_txn("hold1", 32'h0000_0500, 32'h2468_ACE0, 4, -1, 1'b1, 5, 7, 1'b1, 1'b0);
    miss_txn("hold2", 32'h0000_0500, 32'h1111_2222, 0, -1, 1'b1, 4, 6, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    chk("fill_queue_empty", exp_q.size(), 32'd0);

    // 4-bit counters: continuous misses with instant ack drive both to all-ones
    bus4.miss_req  = 1'b1;
    bus4.miss_addr = 32'h0000_0010;
    bus4.mem_ack   = 1'b1;
    bus4.mem_rdata = 32'hCAFE_0001;
    repeat (150) @(negedge clk);
    chk("sat_cnt_stall", {28'd0, cnt_stall4}, 32'h0000_000F);
    chk("sat_cnt_refill", {28'd0, cnt_refill4}, 32'h0000_000F);
    repeat (10) @(negedge clk);
    chk("sat_cnt_stall_hold", {28'd0, cnt_stall4}, 32'h0000_000F);
    chk("sat_cnt_refill_hold", {28'd0, cnt_refill4}, 32'h0000_000F);
    bus4.miss_req = 1'b0;
    bus4.mem_ack  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
